// File: rtl/aie_policy_pkg.sv
// Shared constants, FSM encoding and the fixed-point shift/saturate helper
// for the AIE policy responder.
package aie_policy_pkg;

    localparam int STATE_DIM_DEF  = 6;
    localparam int ACTION_DIM_DEF = 2;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int FRAC_BITS_DEF  = 16;
    localparam int SAT_W          = 128;

    typedef enum logic [2:0] {IDLE, MAC, FINAL, DELAY, SEND} resp_state_t;

    // Floor-shift a wide accumulator by frac and clamp to a dw-bit signed range.
    function automatic logic signed [SAT_W-1:0] sat_shift(
        input logic signed [SAT_W-1:0] acc,
        input int                      frac,
        input int                      dw
    );
        logic signed [SAT_W-1:0] sh;
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sh  = acc >>> frac;
        one = SAT_W'(1);
        hi  = (one <<< (dw - 1)) - one;
        lo  = -(one <<< (dw - 1));
        if (sh > hi) return hi;
        if (sh < lo) return lo;
        return sh;
    endfunction

endpackage

// File: rtl/aie_policy_responder_if.sv
// State/action AXI4-Stream pair between the policy wrapper (master) and the
// responder (slave).
interface aie_policy_responder_if
    import aie_policy_pkg::*;
#(
    parameter int STATE_DIM  = STATE_DIM_DEF,
    parameter int ACTION_DIM = ACTION_DIM_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic                             s_axis_state_tvalid;
    logic [DATA_WIDTH*STATE_DIM-1:0]  s_axis_state_tdata;
    logic                             s_axis_state_tlast;
    logic                             s_axis_state_tready;
    logic                             m_axis_action_tvalid;
    logic [DATA_WIDTH*ACTION_DIM-1:0] m_axis_action_tdata;
    logic                             m_axis_action_tlast;
    logic                             m_axis_action_tready;

    modport master (
        output s_axis_state_tvalid, s_axis_state_tdata, s_axis_state_tlast,
        input  s_axis_state_tready,
        input  m_axis_action_tvalid, m_axis_action_tdata, m_axis_action_tlast,
        output m_axis_action_tready
    );

    modport slave (
        input  s_axis_state_tvalid, s_axis_state_tdata, s_axis_state_tlast,
        output s_axis_state_tready,
        output m_axis_action_tvalid, m_axis_action_tdata, m_axis_action_tlast,
        input  m_axis_action_tready
    );

endinterface

// File: rtl/policy_mac_sat.sv
// Serial signed MAC: clear, accumulate W*x, and a combinational finalize that
// adds the bias, floor-shifts by FRAC_BITS and saturates to DATA_WIDTH.
module policy_mac_sat
    import aie_policy_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF,
    parameter int ACC_W      = 2 * DATA_WIDTH_DEF + 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         acc_en,
    input  logic signed [DATA_WIDTH-1:0] coef,
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic signed [DATA_WIDTH-1:0] result
);

    logic signed [ACC_W-1:0]        acc_q;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        total;

    assign prod   = (2*DATA_WIDTH)'(coef) * (2*DATA_WIDTH)'(x);
    assign total  = acc_q + (ACC_W'(bias) <<< FRAC_BITS);
    assign result = DATA_WIDTH'(sat_shift(SAT_W'(total), FRAC_BITS, DATA_WIDTH));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            acc_q <= '0;
        end else if (acc_en) begin
            acc_q <= acc_q + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/aie_policy_responder.sv
// PL-side linear policy responder: action = W*state + b, one request at a time.
// Optional request/busy statistics ports: define AIE_POLICY_RESP_STATS_EN.
module aie_policy_responder
    import aie_policy_pkg::*;
#(
    parameter int STATE_DIM     = STATE_DIM_DEF,
    parameter int ACTION_DIM    = ACTION_DIM_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int FRAC_BITS     = FRAC_BITS_DEF,
    parameter int EXTRA_LATENCY = 0,
    localparam int N_COEF       = ACTION_DIM * (STATE_DIM + 1),
    localparam int ADDR_W       = $clog2(N_COEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aie_policy_responder_if.slave axis,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_wdata,
    output logic                  busy,
    output logic                  err_tlast
`ifdef AIE_POLICY_RESP_STATS_EN
    ,
    output logic [15:0]           stat_requests,
    output logic [15:0]           stat_busy_cycles
`endif
);

    localparam int A_W = (ACTION_DIM > 1) ? $clog2(ACTION_DIM) : 1;
    localparam int S_W = (STATE_DIM > 1) ? $clog2(STATE_DIM) : 1;
    localparam int D_W = (EXTRA_LATENCY > 1) ? $clog2(EXTRA_LATENCY) : 1;

    resp_state_t                      state;
    logic [A_W-1:0]                   a_q;
    logic [S_W-1:0]                   s_q;
    logic [D_W-1:0]                   dly_q;
    logic [DATA_WIDTH*STATE_DIM-1:0]  x_q;
    logic [DATA_WIDTH*ACTION_DIM-1:0] action_q;
    logic                             s_tready_q;
    logic                             m_tvalid_q;
    logic                             m_tlast_q;
    logic signed [DATA_WIDTH-1:0]     coef_q [N_COEF];
    logic                             accept;
    logic [ADDR_W-1:0]                w_idx;
    logic [ADDR_W-1:0]                b_idx;
    logic signed [DATA_WIDTH-1:0]     mac_x;
    logic signed [DATA_WIDTH-1:0]     mac_result;

    assign accept = s_tready_q && axis.s_axis_state_tvalid;
    assign busy   = (state != IDLE);
    assign w_idx  = ADDR_W'(int'(a_q) * (STATE_DIM + 1) + int'(s_q));
    assign b_idx  = ADDR_W'(int'(a_q) * (STATE_DIM + 1) + STATE_DIM);
    assign mac_x  = x_q[int'(s_q)*DATA_WIDTH +: DATA_WIDTH];

    assign axis.s_axis_state_tready  = s_tready_q;
    assign axis.m_axis_action_tvalid = m_tvalid_q;
    assign axis.m_axis_action_tlast  = m_tlast_q;
    assign axis.m_axis_action_tdata  = action_q;

    // NOTE: the coefficient file is cleared on reset because a mid-run reset must
    // leave the policy at zero; a reset-less RAM would keep the stale weights.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_COEF; i++) coef_q[i] <= '0;
        end else if (cfg_we && !busy && (int'(cfg_addr) < N_COEF)) begin
            coef_q[cfg_addr] <= cfg_wdata;
        end
    end

    policy_mac_sat #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (2 * DATA_WIDTH + $clog2(STATE_DIM + 1))
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept || (state == FINAL)),
        .acc_en(state == MAC),
        .coef  (coef_q[w_idx]),
        .x     (mac_x),
        .bias  (coef_q[b_idx]),
        .result(mac_result)
    );

    // NOTE: every register here uses <=, so each branch reads pre-edge values
    // regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_q        <= '0;
            s_q        <= '0;
            dly_q      <= '0;
            x_q        <= '0;
            action_q   <= '0;
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            err_tlast  <= 1'b0;
        end else begin
            err_tlast <= 1'b0;
            case (state)
                IDLE: begin
                    s_tready_q <= ~accept;
                    if (accept) begin
                        x_q       <= axis.s_axis_state_tdata;
                        a_q       <= '0;
                        s_q       <= '0;
                        err_tlast <= ~axis.s_axis_state_tlast;
                        state     <= MAC;
                    end
                end
                MAC: begin
                    if (s_q == S_W'(STATE_DIM - 1)) state <= FINAL;
                    else                            s_q   <= s_q + 1'b1;
                end
                FINAL: begin
                    action_q[int'(a_q)*DATA_WIDTH +: DATA_WIDTH] <= mac_result;
                    s_q <= '0;
                    if (a_q == A_W'(ACTION_DIM - 1)) begin
                        dly_q <= '0;
                        state <= (EXTRA_LATENCY == 0) ? SEND : DELAY;
                    end else begin
                        a_q   <= a_q + 1'b1;
                        state <= MAC;
                    end
                end
                DELAY: begin
                    if (dly_q == D_W'(EXTRA_LATENCY - 1)) state <= SEND;
                    else                                  dly_q <= dly_q + 1'b1;
                end
                SEND: begin
                    // tvalid rises one edge after entering SEND; action_q is frozen here.
                    if (!m_tvalid_q) begin
                        m_tvalid_q <= 1'b1;
                        m_tlast_q  <= 1'b1;
                    end else if (axis.m_axis_action_tready) begin
                        m_tvalid_q <= 1'b0;
                        m_tlast_q  <= 1'b0;
                        s_tready_q <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AIE_POLICY_RESP_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_requests    <= '0;
            stat_busy_cycles <= '0;
        end else begin
            if (m_tvalid_q && axis.m_axis_action_tready) stat_requests <= stat_requests + 16'd1;
            if (busy && (stat_busy_cycles != 16'hFFFF)) stat_busy_cycles <= stat_busy_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_aie_policy_responder.sv
// Scoreboard bench for aie_policy_responder: expected actions are queued when
// a state beat is driven and compared when the action handshake happens.
module tb_aie_policy_responder;

    localparam int SD = 6;
    localparam int NC = 14;
    localparam int XW = 32 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic        busy;
    logic        err_tlast;
`ifdef AIE_POLICY_RESP_STATS_EN
    logic [15:0] stat_requests;
    logic [15:0] stat_busy_cycles;
`endif

    aie_policy_responder_if ifc ();

    aie_policy_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .axis     (ifc.slave),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .busy     (busy),
        .err_tlast(err_tlast)
`ifdef AIE_POLICY_RESP_STATS_EN
        ,
        .stat_requests   (stat_requests),
        .stat_busy_cycles(stat_busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int              n_checks = 0;
    int              n_err = 0;
    logic [63:0]     exp_q [$];
    logic signed [31:0] w_m [NC];
    int              acc_cyc = -100;
    int              hs_cyc = -100;
    int              err_cnt = 0;
    bit              seen_valid = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp_v, $time);
        end
    endtask

    // Reference: per action, sum W*x in wide precision, add b<<16, floor >>16, clamp.
    function automatic logic [63:0] model(input logic [XW-1:0] x);
        logic [63:0]         r;
        logic signed [127:0] acc;
        logic signed [127:0] bb;
        logic signed [63:0]  p;
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = 128'sd2147483647;
        lo = -128'sd2147483648;
        r  = '0;
        for (int a = 0; a < 2; a++) begin
            acc = '0;
            for (int s = 0; s < SD; s++) begin
                p   = w_m[a*7+s] * $signed(x[s*32 +: 32]);
                acc = acc + p;
            end
            bb  = w_m[a*7+6];
            acc = (acc + (bb <<< 16)) >>> 16;
            if (acc > hi)      r[a*32 +: 32] = 32'h7FFFFFFF;
            else if (acc < lo) r[a*32 +: 32] = 32'h80000000;
            else               r[a*32 +: 32] = acc[31:0];
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_word(input bit big);
        logic [31:0] r;
        if (big) r = $urandom();
        else     r = $urandom_range(32'h3FFFF, 0) - 32'h20000;
        return r;
    endfunction

    function automatic logic [XW-1:0] rnd_vec(input bit big);
        logic [XW-1:0] v;
        for (int s = 0; s < SD; s++) v[s*32 +: 32] = rnd_word(big);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_write(input int addr, input logic [31:0] d, input bit lands);
        cfg_we    = 1'b1;
        cfg_addr  = 4'(addr);
        cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
        if (lands) w_m[addr] = d;
    endtask

    task automatic send_state(input logic [XW-1:0] x, input bit last, input logic [63:0] exp_v);
        ifc.s_axis_state_tdata  = x;
        ifc.s_axis_state_tlast  = last;
        ifc.s_axis_state_tvalid = 1'b1;
        exp_q.push_back(exp_v);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifc.s_axis_state_tready) begin
                acc_cyc = cyc + 1;
                tick();
                ifc.s_axis_state_tvalid = 1'b0;
                return;
            end
            tick();
        end
        check("accept_timeout", 0, 1);
        ifc.s_axis_state_tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !ifc.m_axis_action_tvalid) begin
                tick();
                return;
            end
        end
        check("response_timeout", 64'(exp_q.size()), 0);
        exp_q.delete();
        tick();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.m_axis_action_tvalid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    if (!seen_valid) begin
                        seen_valid = 1'b1;
                        check("latency", 64'(cyc - acc_cyc), 15);
                    end
                    check("busy_while_valid", busy, 1);
                    check("no_accept_while_valid", ifc.s_axis_state_tready, 0);
                    if (ifc.m_axis_action_tready) begin
                        check("action_data", ifc.m_axis_action_tdata, exp_q.pop_front());
                        check("action_tlast", ifc.m_axis_action_tlast, 1);
                        hs_cyc     = cyc + 1;
                        seen_valid = 1'b0;
                    end else begin
                        check("hold_data", ifc.m_axis_action_tdata, exp_q[0]);
                    end
                end
            end
            if (err_tlast) err_cnt++;
        end else begin
            seen_valid = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XW-1:0] x;
        logic [XW-1:0] x2;
        logic [63:0]   e;
        int            e0;

        ifc.s_axis_state_tvalid  = 1'b0;
        ifc.s_axis_state_tdata   = '0;
        ifc.s_axis_state_tlast   = 1'b0;
        ifc.m_axis_action_tready = 1'b1;
        for (int i = 0; i < NC; i++) w_m[i] = '0;

        // Reset values and tready rising one edge after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", ifc.s_axis_state_tready, 0);
        check("rst_m_tvalid", ifc.m_axis_action_tvalid, 0);
        check("rst_m_tdata", ifc.m_axis_action_tdata, 0);
        check("rst_m_tlast", ifc.m_axis_action_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_err_tlast", err_tlast, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("tready_before_first_edge", ifc.s_axis_state_tready, 0);
        @(negedge clk);
        check("tready_after_release", ifc.s_axis_state_tready, 1);
        tick();

        // Zero coefficients give a zero action
        x = {6{32'h00030000}};
        send_state(x, 1'b1, 64'h0);
        wait_idle();
        check("err_tlast_clean", 64'(err_cnt), 0);

        // Directed weights and bias
        cfg_write(0, 32'h00010000, 1'b1);
        cfg_write(8, 32'h00020000, 1'b1);
        cfg_write(13, 32'h00008000, 1'b1);
        x = '0;
        x[31:0]  = 32'h00030000;
        x[63:32] = 32'hFFFEC000;
        send_state(x, 1'b1, {32'hFFFE0000, 32'h00030000});
        wait_idle();

        // Saturation at both rails
        cfg_write(0, 32'h7FFF0000, 1'b1);
        x = '0;
        x[31:0] = 32'h7FFF0000;
        send_state(x, 1'b1, {32'h00008000, 32'h7FFFFFFF});
        wait_idle();
        x[31:0] = 32'h80010000;
        send_state(x, 1'b1, {32'h00008000, 32'h80000000});
        wait_idle();

        // Out-of-range writes are dropped; random coefficient sets
        cfg_write(14, 32'h7FFFFFFF, 1'b0);
        cfg_write(15, 32'h7FFFFFFF, 1'b0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NC; i++) cfg_write(i, rnd_word(k == 3), 1'b1);
            x = rnd_vec(k >= 2);
            send_state(x, 1'b1, model(x));
            wait_idle();
        end

        // A write landing on the accepting edge is used by that request
        x = rnd_vec(1'b0);
        w_m[0] = 32'h00050000;
        e = model(x);
        fork
            send_state(x, 1'b1, e);
            begin
                cfg_we    = 1'b1;
                cfg_addr  = 4'd0;
                cfg_wdata = 32'h00050000;
                tick();
                cfg_we = 1'b0;
            end
        join
        wait_idle();

        // Backpressure: response held, second beat waits for the handshake
        ifc.m_axis_action_tready = 1'b0;
        x = rnd_vec(1'b0);
        send_state(x, 1'b1, model(x));
        x2 = rnd_vec(1'b0);
        fork
            send_state(x2, 1'b1, model(x2));
            begin
                for (int i = 0; i < 40 && !ifc.m_axis_action_tvalid; i++) @(negedge clk);
                repeat (10) @(posedge clk);
                #2 ifc.m_axis_action_tready = 1'b1;
            end
        join
        check("accept_after_handshake", 64'(acc_cyc), 64'(hs_cyc + 1));
        wait_idle();

        // tlast=0 flags one cycle; a write while busy is ignored
        e0 = err_cnt;
        x = rnd_vec(1'b0);
        send_state(x, 1'b0, model(x));
        cfg_write(0, 32'h12340000, 1'b0);
        wait_idle();
        check("err_tlast_pulse", 64'(err_cnt - e0), 1);
        x = rnd_vec(1'b0);
        send_state(x, 1'b1, model(x));
        wait_idle();
        check("err_tlast_total", 64'(err_cnt), 1);

        // Reset during MAC aborts the request and clears the coefficients
        x = rnd_vec(1'b0);
        send_state(x, 1'b1, 64'h0);
        tick();
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NC; i++) w_m[i] = '0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_tready_low", ifc.s_axis_state_tready, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        check("mid_rst_tready_high", ifc.s_axis_state_tready, 1);
        repeat (20) @(negedge clk);
        tick();
        x = {6{32'h00030000}};
        send_state(x, 1'b1, 64'h0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/aie_policy_responder.md
Name: aie_policy_responder

Overview:
- PL-side responder for the policy AXI4-Stream link. It receives one packed radar-state beat and returns one packed action beat.
- It computes a fixed-point linear policy, action = W·state + b, with a serial MAC engine.
- Serves as the AIE stand-in for bring-up and as a fallback policy when the AIE graph is not loaded.
- Sits opposite the policy wrapper: its slave stream is the wrapper's state stream, its master stream is the wrapper's action stream.

Parameters:
- STATE_DIM, 6, number of state words per request beat.
- ACTION_DIM, 2, number of action words per response beat.
- DATA_WIDTH, 32, word width; signed fixed-point.
- FRAC_BITS, 16, fractional bits of all words, Q15.16 by default.
- EXTRA_LATENCY, 0, idle cycles inserted before the response, to emulate AIE inference delay.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- s_axis_state_tvalid  in  1  state beat valid.
- s_axis_state_tdata  in  DATA_WIDTH*STATE_DIM  word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_state_tlast  in  1  must be 1 on every beat.
- s_axis_state_tready  out  1  ready to accept a state beat.
- m_axis_action_tvalid  out  1  action beat valid.
- m_axis_action_tdata  out  DATA_WIDTH*ACTION_DIM  action word a at [a*DATA_WIDTH +: DATA_WIDTH].
- m_axis_action_tlast  out  1  asserted with every action beat.
- m_axis_action_tready  in  1  downstream ready.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  $clog2(ACTION_DIM*(STATE_DIM+1))  coefficient index.
- cfg_wdata  in  DATA_WIDTH  coefficient value.
- busy  out  1  high in every state except IDLE.
- err_tlast  out  1  one-cycle pulse when a beat is accepted with tlast=0.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-low (clk, rst_n).
  - While rst_n=0 at a clk edge: s_axis_state_tready=0, m_axis_action_tvalid=0, tdata=0, tlast=0, busy=0, err_tlast=0, FSM=IDLE, all coefficients=0.
  - s_axis_state_tready rises on the first edge after rst_n=1.
  - Reset mid-operation aborts the request with no response.
- Coefficient map:
  - Index a*(STATE_DIM+1)+s holds W[a][s]; index a*(STATE_DIM+1)+STATE_DIM holds b[a].
  - cfg_we is honoured only when busy=0.
  - Writes are ignored when busy=1 or cfg_addr is out of range.
- FSM IDLE:
  - s_axis_state_tready=1 (registered).
  - On a tvalid&&tready edge: capture tdata into the state register, drop tready, go to MAC, a=0, s=0, acc=0.
  - If tlast=0 on that beat, err_tlast pulses for the next cycle; processing continues.
- FSM MAC:
  - Each cycle: acc += W[a][s]*x[s], signed DATA_WIDTH×DATA_WIDTH → 2*DATA_WIDTH product.
  - Accumulator width is 2*DATA_WIDTH+$clog2(STATE_DIM+1); no overflow is possible.
  - After s=STATE_DIM-1, go to FINAL.
- FSM FINAL (1 cycle):
  - t = acc + (b[a] <<< FRAC_BITS), then arithmetic right shift by FRAC_BITS (floor).
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and store into action word a.
  - If a<ACTION_DIM-1: a++, s=0, acc=0, back to MAC.
  - Otherwise go to DELAY, or to SEND when EXTRA_LATENCY=0.
- FSM DELAY: count EXTRA_LATENCY cycles, then go to SEND.
- FSM SEND:
  - m_axis_action_tvalid=1, tlast=1; tdata holds all action words.
  - tdata is stable while tvalid=1 and tready=0.
  - On a tvalid&&tready edge: drop tvalid and tlast, return to IDLE; s_axis_state_tready=1 on the following cycle.
- Latency:
  - tvalid is first seen high ACTION_DIM*(STATE_DIM+1)+EXTRA_LATENCY+1 edges after the accepting edge; 15 at defaults.
  - Throughput is one request outstanding; s_axis_state_tready=0 from acceptance until the response is consumed.
- Simultaneous cfg_we and state acceptance in IDLE: the write lands, and the new coefficient is used by that request.

Optional Feature:
- Macro: AIE_POLICY_RESP_STATS_EN.
- Defined:
  - Adds outputs stat_requests[15:0], incremented on each action handshake and wrapping at 0xFFFF→0.
  - Adds stat_busy_cycles[15:0], which counts busy cycles and saturates at 0xFFFF.
  - Both counters clear on reset.
- Undefined: neither port nor the counters exist.

Decomposition:
- Package aie_policy_pkg:
  - constants STATE_DIM_DEF, ACTION_DIM_DEF, DATA_WIDTH_DEF, FRAC_BITS_DEF;
  - FSM enum resp_state_t {IDLE, MAC, FINAL, DELAY, SEND};
  - function sat_shift(acc, frac) implementing the shift and saturation.
- Sub-module policy_mac_sat: one signed MAC with clear, accumulate and finalize (bias add, shift, saturate). The FSM, coefficient registers and AXIS handshakes stay in the top.

Test Plan:
- Reset, no cfg writes, state={3.0,…} → action tdata=0, tlast=1, tvalid exactly 15 edges after acceptance, err_tlast=0.
- W[0][0]=0x00010000, W[1][1]=0x00020000, b[1]=0x00008000; x0=0x00030000, x1=0xFFFEC000 (−1.25) → action0=0x00030000, action1=0xFFFE0000 (−2.0).
- Saturation: W[0][0]=0x7FFF0000, x0=0x7FFF0000 → action0=0x7FFFFFFF; x0=0x80010000 → action0=0x80000000.
- Backpressure: m_axis_action_tready=0 for 10 cycles → tvalid/tdata stable, s_axis_state_tready=0, a second state beat is not accepted; it is accepted the cycle after the action handshake plus one.
- tlast=0 on the input beat → err_tlast high exactly one cycle and a normal response; a cfg write while busy=1 has no effect on later results.
- rst_n=0 for one edge during MAC → no response, coefficients read back as zero (next result 0), s_axis_state_tready=1 one edge after release.
